// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator (column/row counters, H/V sync,
// visible-area flag and frame-start pulse).
// Optional feature macro: VGA_FRAME_CNT_EN adds a 16-bit Frame_Count output.
// All outputs are registered from the same next-state values, so counters,
// syncs and Active never skew relative to each other.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    output logic        H_Sync,
    output logic        V_Sync,
    output logic [9:0]  CountCol,
    output logic [9:0]  CountRow,
    output logic        Active,
    output logic        Frame_Start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] Frame_Count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Counters are 10 bits wide, so neither total may exceed 1024. Every phase
    // needs at least one cycle because each FSM state must be visited.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024");
    end
    if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_phase_chk
        $error("vga_timing_gen: every timing phase must be at least 1");
    end

    // Last column/row of each phase; the FSMs leave a phase from these values.
    localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_FP_END  = 10'(H_ACTIVE + H_FRONT - 1);
    localparam logic [9:0] H_SY_END  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_FP_END  = 10'(V_ACTIVE + V_FRONT - 1);
    localparam logic [9:0] V_SY_END  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {H_ACT, H_FP, H_SY, H_BP} h_state_e;
    typedef enum logic [1:0] {V_ACT, V_FP, V_SY, V_BP} v_state_e;

    h_state_e    h_state_q, h_state_d;
    v_state_e    v_state_q, v_state_d;
    logic [9:0]  col_q, col_d, row_q, row_d;
    logic        hs_q, hs_d, vs_q, vs_d, act_q, act_d, fs_q, fs_d;
    logic        line_wrap;

    // Pixel/line counters; the row only moves on the line-wrap edge.
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        line_wrap = EN && (col_q == H_LAST);
        if (EN) begin
            if (line_wrap) begin
                col_d = '0;
                row_d = (row_q == V_LAST) ? '0 : row_q + 10'd1;
            end else begin
                col_d = col_q + 10'd1;
            end
        end
    end

    // Horizontal phase FSM: leaves each phase on its last enabled column.
    always_comb begin
        h_state_d = h_state_q;
        if (EN) begin
            case (h_state_q)
                H_ACT:   if (col_q == H_ACT_END) h_state_d = H_FP;
                H_FP:    if (col_q == H_FP_END)  h_state_d = H_SY;
                H_SY:    if (col_q == H_SY_END)  h_state_d = H_BP;
                H_BP:    if (col_q == H_LAST)    h_state_d = H_ACT;
                default: h_state_d = H_ACT;
            endcase
        end
    end

    // Vertical phase FSM: steps only on the line-wrap edge.
    always_comb begin
        v_state_d = v_state_q;
        if (line_wrap) begin
            case (v_state_q)
                V_ACT:   if (row_q == V_ACT_END) v_state_d = V_FP;
                V_FP:    if (row_q == V_FP_END)  v_state_d = V_SY;
                V_SY:    if (row_q == V_SY_END)  v_state_d = V_BP;
                V_BP:    if (row_q == V_LAST)    v_state_d = V_ACT;
                default: v_state_d = V_ACT;
            endcase
        end
    end

    // Outputs decoded from next state so they register alongside the counters.
    always_comb begin
        hs_d  = (h_state_d == H_SY) ? SYNC_POL : ~SYNC_POL;
        vs_d  = (v_state_d == V_SY) ? SYNC_POL : ~SYNC_POL;
        act_d = (h_state_d == H_ACT) && (v_state_d == V_ACT);
        fs_d  = line_wrap && (row_q == V_LAST);
    end

    // State, counter and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_state_q <= H_ACT;
            v_state_q <= V_ACT;
            col_q     <= '0;
            row_q     <= '0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            act_q     <= 1'b1;
            fs_q      <= 1'b0;
        end else begin
            h_state_q <= h_state_d;
            v_state_q <= v_state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            act_q     <= act_d;
            fs_q      <= fs_d;
        end
    end

    assign H_Sync      = hs_q;
    assign V_Sync      = vs_q;
    assign CountCol    = col_q;
    assign CountRow    = row_q;
    assign Active      = act_q;
    assign Frame_Start = fs_q;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fc_q, fc_d;

    // Frame counter bumps on the same edge that raises Frame_Start.
    always_comb begin
        fc_d = fs_d ? fc_q + 16'd1 : fc_q;
    end

    // Frame counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) fc_q <= '0;
        else     fc_q <= fc_d;
    end

    assign Frame_Count = fc_q;
`endif

endmodule
